mem_copy_master: RTL and testbench
==================================

Name: mem_copy_master

Overview:
Single-requester initiator that drives one read port and one write port of the shared multi-requester memory. On a start command it copies LEN words from a source address range to a destination range, one word at a time. It issues a read, waits for the returned data, then issues a write. It is the requester-side counterpart of the arbitrated memory, used by DMA-style clients and by the memory-subsystem test harness.

Parameters:
DATA_WIDTH, 32, word width; matches the memory.
ADDR_WIDTH, 4, word address width; matches the memory.
LEN_WIDTH, 5, width of the length and progress fields; allows up to 2^ADDR_WIDTH words.
TIMEOUT, 15, maximum cycles spent in RD_WAIT without m_r_dvalid before an error is flagged.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle command pulse; sampled only in IDLE
src_addr  in  ADDR_WIDTH  first source word address
dst_addr  in  ADDR_WIDTH  first destination word address
len  in  LEN_WIDTH  number of words to copy
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle completion pulse
error  out  1  sticky read-timeout flag; cleared by the next accepted start
words_done  out  LEN_WIDTH  number of completed writes
m_r_addr  out  ADDR_WIDTH  read address
m_r_avalid  out  1  read request
m_r_aready  in  1  read request accepted
m_r_dvalid  in  1  read data valid
m_r_data  in  DATA_WIDTH  read data
m_w_addr  out  ADDR_WIDTH  write address
m_w_data  out  DATA_WIDTH  write data
m_w_valid  out  1  write request
m_w_ready  in  1  write accepted

Behaviour:
- All outputs are registered.
- Reset: takes effect at the edge where rst=1 is sampled. Applies at any time, including mid-copy.
  - State goes to IDLE.
  - busy, done, error, words_done, m_r_avalid and m_w_valid all go to 0.
  - Address and data outputs go to 0.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE:
  - start=1 latches src_addr, dst_addr and len; clears error and words_done; sets busy.
  - If len=0, next state is DONE with no memory traffic.
  - Otherwise next state is RD_REQ, with m_r_avalid=1 and m_r_addr=current source address on the next cycle.
  - start in any other state is ignored.
- RD_REQ:
  - m_r_avalid and m_r_addr are held stable until m_r_aready=1 is sampled.
  - m_r_avalid drops the following cycle, and the state becomes RD_WAIT.
  - The wait timer clears.
- RD_WAIT:
  - The first m_r_dvalid=1 captures m_r_data.
  - Next state is WR_REQ, with m_w_valid=1, m_w_addr=current destination address and m_w_data=captured word.
  - m_r_dvalid is ignored in every other state. This discards duplicate returns caused by the arbiter re-granting a held request.
  - If TIMEOUT cycles elapse without m_r_dvalid, error is set, no write is issued, and the state goes to DONE.
- WR_REQ:
  - m_w_valid, m_w_addr and m_w_data are held until m_w_ready=1 is sampled.
  - The following cycle:
    - m_w_valid drops.
    - words_done increments.
    - Source and destination addresses each increment by 1 modulo 2^ADDR_WIDTH (wrap 15 to 0).
  - If words_done reaches len, next state is DONE; otherwise RD_REQ.
  - A repeated write of the same word at the same address, caused by the registered ready, is permitted and benign.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - words_done and error hold until the next accepted start.
- Throughput: a copy takes at least 6 cycles per word against a memory with DATA_LAT=2 and no contention.
- Simultaneous m_r_aready and m_r_dvalid in RD_REQ: the dvalid is ignored.

Decomposition:
- Package mem_copy_pkg:
  - state enum (IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE);
  - constant for the timer width, $clog2(TIMEOUT+1).
- One sub-module, wait_timer: loadable down-counter with clear, enable and an expired output. Instantiated once for RD_WAIT.
- Everything else stays in mem_copy_master.

Test Plan:
1. Memory model with DATA_LAT=2 preloaded with mem[2..5]=A,B,C,D; start src=2 dst=8 len=4 -> mem[8..11]=A,B,C,D; 4 read accepts and 4 write accepts; done pulses once; words_done=4; error=0.
2. start with len=0 -> done pulses in the cycle after DONE is entered; m_r_avalid and m_w_valid never assert; words_done=0.
3. start src=14 dst=0 len=4 -> reads issued at 14,15,0,1; writes issued at 0,1,2,3.
4. Hold m_r_aready low for 5 cycles, then m_w_ready low for 3 cycles -> m_r_avalid/m_r_addr and m_w_valid/m_w_addr/m_w_data stay stable throughout; data is still copied correctly.
5. m_r_dvalid held low -> error=1 after 15 RD_WAIT cycles; done pulses; no m_w_valid; the next start clears error.
6. Assert rst for 1 cycle after 2 of 4 words are copied -> next cycle all outputs are 0 and the state is IDLE; a new start then completes a full copy.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// rtl/mem_copy_pkg.sv - shared types and sizing helpers for the memory copy initiator
package mem_copy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    DONE
  } state_e;

  localparam int TIMEOUT_DEFAULT = 15;

  function automatic int timer_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_copy_master_wait_timer.sv
// rtl/mem_copy_master_wait_timer.sv - loadable saturating down-counter bounding the read-data wait
module wait_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/mem_copy_master.sv
// rtl/mem_copy_master.sv - word-by-word copy initiator driving one read and one write memory port
module mem_copy_master
  import mem_copy_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 5,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [LEN_WIDTH-1:0]  words_done,
  output logic [ADDR_WIDTH-1:0] m_r_addr,
  output logic                  m_r_avalid,
  input  logic                  m_r_aready,
  input  logic                  m_r_dvalid,
  input  logic [DATA_WIDTH-1:0] m_r_data,
  output logic [ADDR_WIDTH-1:0] m_w_addr,
  output logic [DATA_WIDTH-1:0] m_w_data,
  output logic                  m_w_valid,
  input  logic                  m_w_ready
);

  localparam int TMR_W = timer_width(TIMEOUT);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   src_q, src_d, dst_q, dst_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d, words_q, words_d, words_inc;
  logic                    busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [ADDR_WIDTH-1:0]   r_addr_q, r_addr_d, w_addr_q, w_addr_d;
  logic                    r_avalid_q, r_avalid_d, w_valid_q, w_valid_d;
  logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
  logic                    tmr_load, tmr_en, tmr_expired;

  // Loaded with TIMEOUT-1 so expiry lands on the TIMEOUT-th RD_WAIT cycle.
  wait_timer #(.WIDTH(TMR_W)) u_wait_timer (
    .clk      (clk),
    .clr      (rst),
    .load     (tmr_load),
    .load_val (TMR_W'(TIMEOUT - 1)),
    .en       (tmr_en),
    .expired  (tmr_expired)
  );

  assign tmr_load  = (state_q == RD_REQ) && m_r_aready;
  assign tmr_en    = (state_q == RD_WAIT);
  assign words_inc = words_q + LEN_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    words_d    = words_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    r_addr_d   = r_addr_q;
    r_avalid_d = r_avalid_q;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    w_valid_d  = w_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = len;
          words_d = '0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          if (len == '0) begin
            state_d = DONE;
          end else begin
            state_d    = RD_REQ;
            r_avalid_d = 1'b1;
            r_addr_d   = src_addr;
          end
        end
      end
      RD_REQ: begin
        if (m_r_aready) begin
          r_avalid_d = 1'b0;
          state_d    = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (m_r_dvalid) begin
          w_data_d  = m_r_data;
          w_addr_d  = dst_q;
          w_valid_d = 1'b1;
          state_d   = WR_REQ;
        end else if (tmr_expired) begin
          error_d = 1'b1;
          state_d = DONE;
        end
      end
      WR_REQ: begin
        if (m_w_ready) begin
          w_valid_d = 1'b0;
          words_d   = words_inc;
          src_d     = src_q + ADDR_WIDTH'(1);
          dst_d     = dst_q + ADDR_WIDTH'(1);
          if (words_inc == len_q) begin
            state_d = DONE;
          end else begin
            state_d    = RD_REQ;
            r_avalid_d = 1'b1;
            r_addr_d   = src_q + ADDR_WIDTH'(1);
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      words_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      r_addr_q   <= '0;
      r_avalid_q <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      w_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      words_q    <= words_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      r_addr_q   <= r_addr_d;
      r_avalid_q <= r_avalid_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      w_valid_q  <= w_valid_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign words_done = words_q;
  assign m_r_addr   = r_addr_q;
  assign m_r_avalid = r_avalid_q;
  assign m_w_addr   = w_addr_q;
  assign m_w_data   = w_data_q;
  assign m_w_valid  = w_valid_q;

endmodule

// File: tb/tb_mem_copy_master.sv
// tb/tb_mem_copy_master.sv - randomized bench with memory model and copy reference for mem_copy_master
module tb_mem_copy_master;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, error;
  logic [LW-1:0] words_done;
  logic [AW-1:0] m_r_addr;
  logic          m_r_avalid;
  logic          m_r_aready = 1'b0;
  logic          m_r_dvalid = 1'b0;
  logic [DW-1:0] m_r_data = '0;
  logic [AW-1:0] m_w_addr;
  logic [DW-1:0] m_w_data;
  logic          m_w_valid;
  logic          m_w_ready = 1'b0;

  always #5 clk = ~clk;

  mem_copy_master dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .words_done (words_done),
    .m_r_addr   (m_r_addr),
    .m_r_avalid (m_r_avalid),
    .m_r_aready (m_r_aready),
    .m_r_dvalid (m_r_dvalid),
    .m_r_data   (m_r_data),
    .m_w_addr   (m_w_addr),
    .m_w_data   (m_w_data),
    .m_w_valid  (m_w_valid),
    .m_w_ready  (m_w_ready)
  );

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] mem [16];
  int            exp_rd[$];
  int            exp_wa[$];
  logic [DW-1:0] exp_wd[$];
  int            rd_log[$];
  int            wr_log[$];
  bit            rst_req = 1'b0, start_req = 1'b0, rnd_ready = 1'b0, no_return = 1'b0;
  int            hold_r = 0, hold_w = 0, ret_cnt = -1, cyc = 0;
  int            n_rfire = 0, n_wfire = 0, n_done = 0, last_rfire_cyc = 0, err_rise_cyc = 0;
  logic [DW-1:0] ret_data = '0;
  bit            dup_next = 1'b0, prev_rst = 1'b1, prev_rfire = 1'b0, prev_wfire = 1'b0;
  bit            prev_av = 1'b0, prev_wv = 1'b0, prev_err = 1'b0;
  logic [AW-1:0] prev_ra = '0, prev_wa = '0;
  logic [DW-1:0] prev_wd = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle: apply pending commands, check outputs, play the memory, record handshakes.
  task automatic tick();
    bit rf, wf;
    @(negedge clk);
    rst       = rst_req;
    start     = start_req;
    rst_req   = 1'b0;
    start_req = 1'b0;
    cyc++;
    if (!prev_rst) begin
      if (prev_av && !prev_rfire) begin
        check("r_hold_valid", m_r_avalid, 1);
        check("r_hold_addr", m_r_addr, prev_ra);
      end
      if (prev_wv && !prev_wfire) begin
        check("w_hold_valid", m_w_valid, 1);
        check("w_hold_addr", m_w_addr, prev_wa);
        check("w_hold_data", m_w_data, prev_wd);
      end
    end
    if (done) begin
      n_done++;
      check("done_not_busy", busy, 0);
    end
    if (m_r_avalid || m_w_valid) check("busy_during_traffic", busy, 1);
    if (error && !prev_err) err_rise_cyc = cyc;

    m_r_dvalid = 1'b0;
    m_r_data   = $urandom;
    if (ret_cnt == 0) begin
      m_r_dvalid = 1'b1;
      m_r_data   = ret_data;
    end else if (dup_next) begin
      m_r_dvalid = ($urandom % 2) == 1;
    end else if (ret_cnt < 0 && m_r_avalid) begin
      m_r_dvalid = ($urandom % 4) == 0;
    end
    dup_next = (ret_cnt == 0);
    if (ret_cnt >= 0) ret_cnt--;

    if (m_r_avalid && hold_r > 0) begin
      m_r_aready = 1'b0;
      hold_r--;
    end else begin
      m_r_aready = rnd_ready ? (($urandom % 3) != 0) : 1'b1;
    end
    if (m_w_valid && hold_w > 0) begin
      m_w_ready = 1'b0;
      hold_w--;
    end else begin
      m_w_ready = rnd_ready ? (($urandom % 3) != 0) : 1'b1;
    end

    rf = !rst && m_r_avalid && m_r_aready;
    wf = !rst && m_w_valid && m_w_ready;
    if (rf) begin
      n_rfire++;
      last_rfire_cyc = cyc;
      rd_log.push_back(int'(m_r_addr));
      check("rd_pending", exp_rd.size() != 0, 1);
      if (exp_rd.size() != 0) check("rd_addr", m_r_addr, exp_rd.pop_front());
      if (!no_return) begin
        ret_cnt  = 1 + (rnd_ready ? int'($urandom % 4) : 0);
        ret_data = mem[m_r_addr];
      end
    end
    if (wf) begin
      n_wfire++;
      wr_log.push_back(int'(m_w_addr));
      check("wr_pending", exp_wa.size() != 0, 1);
      if (exp_wa.size() != 0) begin
        check("wr_addr", m_w_addr, exp_wa.pop_front());
        check("wr_data", m_w_data, exp_wd.pop_front());
      end
      mem[m_w_addr] = m_w_data;
    end
    if (rst) begin
      ret_cnt  = -1;
      dup_next = 1'b0;
    end
    prev_rst   = rst;
    prev_rfire = rf;
    prev_wfire = wf;
    prev_av    = m_r_avalid;
    prev_wv    = m_w_valid;
    prev_err   = error;
    prev_ra    = m_r_addr;
    prev_wa    = m_w_addr;
    prev_wd    = m_w_data;
  endtask

  // Reference: sequential word copy over an image of memory, wrapping addresses mod 16.
  task automatic plan_copy(input int s, input int d, input int l);
    logic [DW-1:0] img [16];
    img = mem;
    for (int i = 0; i < l; i++) begin
      int a = (s + i) % 16;
      int b = (d + i) % 16;
      exp_rd.push_back(a);
      exp_wa.push_back(b);
      exp_wd.push_back(img[a]);
      img[b] = img[a];
    end
  endtask

  task automatic run_cmd(input int s, input int d, input int l, input bit exp_err,
                         input int exp_words, output int wait_ticks);
    int d0;
    d0 = n_done;
    src_addr  = AW'(s);
    dst_addr  = AW'(d);
    len       = LW'(l);
    start_req = 1'b1;
    tick();
    tick();
    check("busy_after_start", busy, 1);
    check("error_cleared_on_start", error, 0);
    check("words_cleared_on_start", words_done, 0);
    check("no_early_done", done, 0);
    wait_ticks = 0;
    while (n_done == d0 && wait_ticks < 3000) begin
      tick();
      wait_ticks++;
    end
    check("done_seen", n_done - d0, 1);
    tick();
    check("done_single_pulse", n_done - d0, 1);
    check("done_low_after", done, 0);
    check("busy_low_after", busy, 0);
    check("words_done", words_done, exp_words);
    check("error_final", error, exp_err);
    check("reads_all_issued", exp_rd.size(), 0);
    check("writes_all_issued", exp_wa.size(), 0);
  endtask

  initial begin
    int wt, r0, w0, budget;
    int er[4];
    int ew[4];
    for (int i = 0; i < 16; i++) mem[i] = $urandom;

    rst_req = 1'b1;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_words", words_done, 0);
    check("rst_avalid", m_r_avalid, 0);
    check("rst_wvalid", m_w_valid, 0);

    mem[2] = 32'hA1A1_0001;
    mem[3] = 32'hB2B2_0002;
    mem[4] = 32'hC3C3_0003;
    mem[5] = 32'hD4D4_0004;
    r0 = n_rfire;
    w0 = n_wfire;
    plan_copy(2, 8, 4);
    run_cmd(2, 8, 4, 0, 4, wt);
    check("t1_mem8", mem[8], 32'hA1A1_0001);
    check("t1_mem9", mem[9], 32'hB2B2_0002);
    check("t1_mem10", mem[10], 32'hC3C3_0003);
    check("t1_mem11", mem[11], 32'hD4D4_0004);
    check("t1_read_accepts", n_rfire - r0, 4);
    check("t1_write_accepts", n_wfire - w0, 4);

    r0 = n_rfire;
    w0 = n_wfire;
    run_cmd(7, 3, 0, 0, 0, wt);
    check("t2_done_latency", wt, 1);
    check("t2_no_reads", n_rfire - r0, 0);
    check("t2_no_writes", n_wfire - w0, 0);

    rd_log.delete();
    wr_log.delete();
    plan_copy(14, 0, 4);
    run_cmd(14, 0, 4, 0, 4, wt);
    er = '{14, 15, 0, 1};
    ew = '{0, 1, 2, 3};
    check("t3_read_count", rd_log.size(), 4);
    check("t3_write_count", wr_log.size(), 4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++) check("t3_read_addr", rd_log[i], er[i]);
    for (int i = 0; i < 4 && i < wr_log.size(); i++) check("t3_write_addr", wr_log[i], ew[i]);

    hold_r = 5;
    hold_w = 3;
    plan_copy(3, 12, 2);
    run_cmd(3, 12, 2, 0, 2, wt);
    check("t4_read_hold_used", hold_r, 0);
    check("t4_write_hold_used", hold_w, 0);

    no_return = 1'b1;
    w0 = n_wfire;
    exp_rd.push_back(5);
    run_cmd(5, 9, 3, 1, 0, wt);
    no_return = 1'b0;
    check("t5_timeout_cycles", err_rise_cyc - last_rfire_cyc, 16);
    check("t5_no_writes", n_wfire - w0, 0);
    plan_copy(5, 9, 3);
    run_cmd(5, 9, 3, 0, 3, wt);

    w0 = n_wfire;
    plan_copy(0, 6, 4);
    src_addr  = AW'(0);
    dst_addr  = AW'(6);
    len       = LW'(4);
    start_req = 1'b1;
    budget    = 0;
    tick();
    while (n_wfire - w0 < 2 && budget < 500) begin
      tick();
      budget++;
    end
    check("t6_two_writes", n_wfire - w0, 2);
    rst_req = 1'b1;
    tick();
    tick();
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_error", error, 0);
    check("t6_words", words_done, 0);
    check("t6_avalid", m_r_avalid, 0);
    check("t6_wvalid", m_w_valid, 0);
    check("t6_raddr", m_r_addr, 0);
    check("t6_waddr", m_w_addr, 0);
    check("t6_wdata", m_w_data, 0);
    exp_rd.delete();
    exp_wa.delete();
    exp_wd.delete();
    plan_copy(0, 6, 4);
    run_cmd(0, 6, 4, 0, 4, wt);

    rnd_ready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      int s, d, l;
      s = int'($urandom % 16);
      d = int'($urandom % 16);
      l = int'($urandom % 17);
      plan_copy(s, d, l);
      run_cmd(s, d, l, 0, l, wt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
